// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the IF/MEM stages, the port arbiter and the RAM macro.
// slave = arbiter side, master = pipeline/RAM side.
interface mem_port_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_rvalid;
  logic          if_stall;
  logic          mem_rd;
  logic          mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_rvalid;
  logic          int_req;
  logic          int_ack;
  logic          pc_load;
  logic [AW-1:0] pc_load_val;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic          ram_we;
  logic          ram_re;
  logic [DW-1:0] ram_rdata;

  modport slave (
    input  if_req, if_addr,
    input  mem_rd, mem_wr, mem_addr, mem_wdata,
    input  int_req, ram_rdata,
    output if_rdata, if_rvalid, if_stall,
    output mem_rdata, mem_rvalid,
    output int_ack, pc_load, pc_load_val,
    output ram_addr, ram_wdata, ram_we, ram_re
  );

  modport master (
    output if_req, if_addr,
    output mem_rd, mem_wr, mem_addr, mem_wdata,
    output int_req, ram_rdata,
    input  if_rdata, if_rvalid, if_stall,
    input  mem_rdata, mem_rvalid,
    input  int_ack, pc_load, pc_load_val,
    input  ram_addr, ram_wdata, ram_we, ram_re
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter: fetch vs memory stage, boot and interrupt vectors.
// Optional perf counters under MEM_ARB_PERF_EN.
module mem_port_arbiter #(
  parameter int            AW      = 8,
  parameter int            DW      = 8,
  parameter logic [AW-1:0] RST_VEC = '0,
  parameter logic [AW-1:0] INT_VEC = AW'(1)
`ifdef MEM_ARB_PERF_EN
  ,
  parameter int            CW      = 16
`endif
) (
  input  logic clk,
  input  logic rst_n,
  mem_port_arbiter_if.slave bus
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [CW-1:0] perf_stall_cnt,
  output logic [CW-1:0] perf_data_cnt
`endif
);

  typedef enum logic [2:0] {
    BOOT_RD,
    BOOT_WT,
    RUN,
    INT_RD,
    INT_WT
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic          data_req;
  logic          data_go;
  logic          rd_go;
  logic          if_go;
  logic          int_go;
  logic          vec_ld;
  logic [AW-1:0] addr_c;
  logic          re_c;
  logic          we_c;
  logic          stall_c;
  logic [DW-1:0] rdata;

  assign data_req = bus.mem_rd | bus.mem_wr;
  assign rdata    = bus.ram_rdata;

  // Next state and port steering; data access beats interrupt beats fetch.
  always_comb begin
    state_nx = state;
    data_go  = 1'b0;
    rd_go    = 1'b0;
    if_go    = 1'b0;
    int_go   = 1'b0;
    addr_c   = bus.if_addr;
    re_c     = 1'b0;
    we_c     = 1'b0;
    stall_c  = 1'b1;
    unique case (state)
      BOOT_RD: begin
        re_c     = 1'b1;
        addr_c   = RST_VEC;
        state_nx = BOOT_WT;
      end
      BOOT_WT: state_nx = RUN;
      RUN: begin
        stall_c = 1'b0;
        if (data_req) begin
          data_go = 1'b1;
          stall_c = 1'b1;
        end else if (bus.int_req) begin
          int_go   = 1'b1;
          state_nx = INT_RD;
        end else if (bus.if_req) begin
          if_go = 1'b1;
          re_c  = 1'b1;
        end
      end
      INT_RD: begin
        if (data_req) begin
          data_go = 1'b1;
        end else begin
          re_c     = 1'b1;
          addr_c   = INT_VEC;
          state_nx = INT_WT;
        end
      end
      INT_WT: state_nx = RUN;
      default: state_nx = BOOT_RD;
    endcase
    if (data_go) begin
      addr_c = bus.mem_addr;
      we_c   = bus.mem_wr;
      re_c   = ~bus.mem_wr;
      rd_go  = ~bus.mem_wr;
    end
  end

  assign vec_ld = (state_nx == BOOT_WT) || (state_nx == INT_WT);

  // Reset gates the strobes so an in-flight write drops at once.
  assign bus.ram_addr    = addr_c;
  assign bus.ram_wdata   = bus.mem_wdata;
  assign bus.ram_we      = we_c & rst_n;
  assign bus.ram_re      = re_c & rst_n;
  assign bus.if_stall    = stall_c;
  assign bus.if_rdata    = rdata;
  assign bus.mem_rdata   = rdata;
  assign bus.pc_load_val = bus.pc_load ? AW'(rdata) : '0;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= BOOT_RD;
    else        state <= state_nx;
  end

  // Registered valid/ack/load strobes, one cycle after the RAM request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.if_rvalid  <= 1'b0;
      bus.mem_rvalid <= 1'b0;
      bus.int_ack    <= 1'b0;
      bus.pc_load    <= 1'b0;
    end else begin
      bus.if_rvalid  <= if_go;
      bus.mem_rvalid <= rd_go;
      bus.int_ack    <= int_go;
      bus.pc_load    <= vec_ld;
    end
  end

`ifdef MEM_ARB_PERF_EN
  logic stall_inc;

  assign stall_inc = (state == RUN) && bus.if_req && stall_c;

  // Saturating counters for fetch stalls and granted data accesses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cnt <= '0;
      perf_data_cnt  <= '0;
    end else begin
      if (stall_inc && (perf_stall_cnt != '1))
        perf_stall_cnt <= perf_stall_cnt + 1'b1;
      if (data_go && (perf_data_cnt != '1))
        perf_data_cnt <= perf_data_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed vector bench for mem_port_arbiter with a behavioural sync RAM.
// Per-cycle table plus hand sequences for reset and perf counters.
module tb_mem_port_arbiter;

  logic clk;
  logic rst_n;
  logic [7:0] mem [256];
  int n_chk;
  int n_pass;

  mem_port_arbiter_if #(.AW(8), .DW(8)) bus ();

`ifdef MEM_ARB_PERF_EN
  logic [15:0] perf_stall_cnt;
  logic [15:0] perf_data_cnt;
`endif

  mem_port_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef MEM_ARB_PERF_EN
    ,
    .perf_stall_cnt (perf_stall_cnt),
    .perf_data_cnt  (perf_data_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
    if (bus.ram_re) bus.ram_rdata <= mem[bus.ram_addr];
  end

  typedef struct {
    logic       ifr;
    logic [7:0] ifa;
    logic       mrd;
    logic       mwr;
    logic [7:0] ma;
    logic [7:0] mwd;
    logic       irq;
    logic [7:0] raddr;
    logic       re;
    logic       we;
    logic       stall;
    logic       ifv;
    logic [7:0] ifd;
    logic       mv;
    logic [7:0] md;
    logic       ack;
    logic       pcl;
    logic [7:0] pcv;
  } vec_t;

  vec_t tbl [28];

  function automatic vec_t mk(
    input logic ifr, input logic [7:0] ifa,
    input logic mrd, input logic mwr,
    input logic [7:0] ma, input logic [7:0] mwd,
    input logic irq, input logic [7:0] raddr,
    input logic re, input logic we, input logic stall,
    input logic ifv, input logic [7:0] ifd,
    input logic mv, input logic [7:0] md,
    input logic ack, input logic pcl,
    input logic [7:0] pcv);
    vec_t v;
    v.ifr = ifr; v.ifa = ifa; v.mrd = mrd; v.mwr = mwr;
    v.ma = ma; v.mwd = mwd; v.irq = irq; v.raddr = raddr;
    v.re = re; v.we = we; v.stall = stall; v.ifv = ifv;
    v.ifd = ifd; v.mv = mv; v.md = md; v.ack = ack;
    v.pcl = pcl; v.pcv = pcv;
    return v;
  endfunction

  task automatic chk(input string nm,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", nm, got, exp);
  endtask

  task automatic idle_in();
    bus.if_req    = 1'b0;
    bus.if_addr   = 8'h00;
    bus.mem_rd    = 1'b0;
    bus.mem_wr    = 1'b0;
    bus.mem_addr  = 8'h00;
    bus.mem_wdata = 8'h00;
    bus.int_req   = 1'b0;
  endtask

  logic [63:0] got;
  logic [63:0] exp;

  initial begin
    n_chk  = 0;
    n_pass = 0;
    rst_n  = 1'b0;
    bus.ram_rdata = 8'h00;
    idle_in();
    for (int a = 0; a < 256; a++) mem[a] = 8'h00;
    mem[8'h00] = 8'h20;
    mem[8'h01] = 8'h80;
    mem[8'h20] = 8'hA1;
    mem[8'h21] = 8'hB2;
    mem[8'h22] = 8'hC3;
    mem[8'h23] = 8'hD4;
    mem[8'h40] = 8'h5A;

    // ifr ifa mrd mwr ma mwd irq | raddr re we stall ifv ifd mv md ack pcl pcv
    tbl[0]  = mk(0,8'h00,0,0,8'h00,8'h00,0, 8'h00,1,0,1, 0,8'h00,0,8'h00,0,0,8'h00);
    tbl[1]  = mk(0,8'h00,0,0,8'h00,8'h00,0, 8'h00,0,0,1, 0,8'h00,0,8'h00,0,1,8'h20);
    tbl[2]  = mk(1,8'h20,0,0,8'h00,8'h00,0, 8'h20,1,0,0, 0,8'h00,0,8'h00,0,0,8'h00);
    tbl[3]  = mk(1,8'h21,0,0,8'h00,8'h00,0, 8'h21,1,0,0, 1,8'hA1,0,8'h00,0,0,8'h00);
    tbl[4]  = mk(1,8'h22,0,0,8'h00,8'h00,0, 8'h22,1,0,0, 1,8'hB2,0,8'h00,0,0,8'h00);
    tbl[5]  = mk(1,8'h23,1,0,8'h40,8'h00,0, 8'h40,1,0,1, 1,8'hC3,0,8'h00,0,0,8'h00);
    tbl[6]  = mk(1,8'h23,0,0,8'h00,8'h00,0, 8'h23,1,0,0, 0,8'h00,1,8'h5A,0,0,8'h00);
    tbl[7]  = mk(0,8'h00,0,0,8'h00,8'h00,0, 8'h00,0,0,0, 1,8'hD4,0,8'h00,0,0,8'h00);
    tbl[8]  = mk(1,8'h24,0,1,8'hF0,8'h99,0, 8'hF0,0,1,1, 0,8'h00,0,8'h00,0,0,8'h00);
    tbl[9]  = mk(0,8'h00,1,0,8'hF0,8'h00,0, 8'hF0,1,0,1, 0,8'h00,0,8'h00,0,0,8'h00);
    tbl[10] = mk(0,8'h00,1,1,8'hF1,8'h77,0, 8'hF1,0,1,1, 0,8'h00,1,8'h99,0,0,8'h00);
    tbl[11] = mk(0,8'h00,1,0,8'hF1,8'h00,0, 8'hF1,1,0,1, 0,8'h00,0,8'h00,0,0,8'h00);
    tbl[12] = mk(0,8'h00,0,0,8'h00,8'h00,0, 8'h00,0,0,0, 0,8'h00,1,8'h77,0,0,8'h00);
    tbl[13] = mk(0,8'h00,0,0,8'h00,8'h00,1, 8'h00,0,0,0, 0,8'h00,0,8'h00,0,0,8'h00);
    tbl[14] = mk(0,8'h00,0,0,8'h00,8'h00,1, 8'h01,1,0,1, 0,8'h00,0,8'h00,1,0,8'h00);
    tbl[15] = mk(0,8'h00,0,0,8'h00,8'h00,0, 8'h00,0,0,1, 0,8'h00,0,8'h00,0,1,8'h80);
    tbl[16] = mk(0,8'h00,0,0,8'h00,8'h00,0, 8'h00,0,0,0, 0,8'h00,0,8'h00,0,0,8'h00);
    tbl[17] = mk(0,8'h00,0,1,8'hF2,8'h11,1, 8'hF2,0,1,1, 0,8'h00,0,8'h00,0,0,8'h00);
    tbl[18] = mk(0,8'h00,0,0,8'h00,8'h00,1, 8'h00,0,0,0, 0,8'h00,0,8'h00,0,0,8'h00);
    tbl[19] = mk(0,8'h00,0,0,8'h00,8'h00,0, 8'h01,1,0,1, 0,8'h00,0,8'h00,1,0,8'h00);
    tbl[20] = mk(0,8'h00,0,0,8'h00,8'h00,0, 8'h00,0,0,1, 0,8'h00,0,8'h00,0,1,8'h80);
    tbl[21] = mk(1,8'h20,0,0,8'h00,8'h00,0, 8'h20,1,0,0, 0,8'h00,0,8'h00,0,0,8'h00);
    tbl[22] = mk(0,8'h00,0,0,8'h00,8'h00,0, 8'h00,0,0,0, 1,8'hA1,0,8'h00,0,0,8'h00);
    tbl[23] = mk(0,8'h00,0,0,8'h00,8'h00,1, 8'h00,0,0,0, 0,8'h00,0,8'h00,0,0,8'h00);
    tbl[24] = mk(0,8'h00,1,0,8'h40,8'h00,0, 8'h40,1,0,1, 0,8'h00,0,8'h00,1,0,8'h00);
    tbl[25] = mk(0,8'h00,0,0,8'h00,8'h00,0, 8'h01,1,0,1, 0,8'h00,1,8'h5A,0,0,8'h00);
    tbl[26] = mk(0,8'h00,0,0,8'h00,8'h00,0, 8'h00,0,0,1, 0,8'h00,0,8'h00,0,1,8'h80);
    tbl[27] = mk(0,8'h00,0,0,8'h00,8'h00,0, 8'h00,0,0,0, 0,8'h00,0,8'h00,0,0,8'h00);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_state",
        {bus.ram_re, bus.ram_we, bus.if_stall, bus.if_rvalid,
         bus.mem_rvalid, bus.int_ack, bus.pc_load, bus.pc_load_val},
        {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00});

    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 28; i++) begin
      bus.if_req    = tbl[i].ifr;
      bus.if_addr   = tbl[i].ifa;
      bus.mem_rd    = tbl[i].mrd;
      bus.mem_wr    = tbl[i].mwr;
      bus.mem_addr  = tbl[i].ma;
      bus.mem_wdata = tbl[i].mwd;
      bus.int_req   = tbl[i].irq;
      @(negedge clk);
      got = 64'({bus.ram_re, bus.ram_we, bus.if_stall,
                 bus.if_rvalid,
                 (tbl[i].ifv ? bus.if_rdata : 8'h00),
                 bus.mem_rvalid,
                 (tbl[i].mv ? bus.mem_rdata : 8'h00),
                 bus.int_ack, bus.pc_load, bus.pc_load_val,
                 ((tbl[i].re | tbl[i].we) ? bus.ram_addr : 8'h00)});
      exp = 64'({tbl[i].re, tbl[i].we, tbl[i].stall,
                 tbl[i].ifv, tbl[i].ifd,
                 tbl[i].mv, tbl[i].md,
                 tbl[i].ack, tbl[i].pcl, tbl[i].pcv,
                 tbl[i].raddr});
      chk($sformatf("row%0d", i), got, exp);
      @(posedge clk);
      #1;
    end

    chk("mem_F0", 64'(mem[8'hF0]), 64'h99);
    chk("mem_F1", 64'(mem[8'hF1]), 64'h77);
    chk("mem_F2", 64'(mem[8'hF2]), 64'h11);
`ifdef MEM_ARB_PERF_EN
    chk("perf_stall", 64'(perf_stall_cnt), 64'd2);
    chk("perf_data", 64'(perf_data_cnt), 64'd7);
`endif

    idle_in();
    bus.mem_wr    = 1'b1;
    bus.mem_addr  = 8'hF3;
    bus.mem_wdata = 8'h55;
    #2;
    chk("midwr_we_before", 64'(bus.ram_we), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midwr_rst_out",
        {bus.ram_we, bus.ram_re, bus.if_stall, bus.pc_load,
         bus.if_rvalid, bus.mem_rvalid, bus.int_ack},
        {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
`ifdef MEM_ARB_PERF_EN
    chk("perf_clear",
        64'({perf_stall_cnt, perf_data_cnt}), 64'd0);
`endif
    @(posedge clk);
    #1;
    chk("midwr_no_commit", 64'(mem[8'hF3]), 64'h00);
    idle_in();
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reboot_rd",
        {bus.ram_re, bus.ram_addr, bus.if_stall},
        {1'b1, 8'h00, 1'b1});
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("reboot_pcload",
        {bus.pc_load, bus.pc_load_val, bus.if_stall},
        {1'b1, 8'h20, 1'b1});
    @(posedge clk);
    #1 bus.if_req = 1'b1;
    bus.if_addr = 8'h21;
    @(negedge clk);
    chk("reboot_run",
        {bus.if_stall, bus.ram_re, bus.ram_addr, bus.pc_load},
        {1'b0, 1'b1, 8'h21, 1'b0});
    @(posedge clk);
    #1 idle_in();
    @(negedge clk);
    chk("reboot_fetch",
        {bus.if_rvalid, bus.if_rdata},
        {1'b1, 8'hB2});

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
